pc_predict: RTL and testbench

//  Parametrised fetch-PC unit for the pipelined MIPS core; successor to the single-cycle PC register.

---
 rtl/pc_pkg.sv | 38 +++
 rtl/pc_btb.sv | 64 ++++++
 rtl/pc_predict.sv | 84 ++++++++
 tb/tb_pc_predict.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types for the fetch-PC unit: BTB entry layout, 2-bit counter encodings
// and helpers that size the BTB index/tag from the depth.
package pc_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_STRONG_NT = 2'b00;
    localparam ctr_t CTR_WEAK_NT   = 2'b01;
    localparam ctr_t CTR_WEAK_T    = 2'b10;
    localparam ctr_t CTR_STRONG_T  = 2'b11;

    // Widest tag (BTB_ENTRIES=2); narrower tags are stored zero-extended.
    localparam int TAG_MAX_W = 29;

    function automatic int idx_w(input int entries);
        return $clog2(entries);
    endfunction

    function automatic int tag_w(input int entries);
        return 30 - $clog2(entries);
    endfunction

    function automatic ctr_t ctr_inc(input ctr_t c);
        return (c == CTR_STRONG_T) ? c : c + 2'd1;
    endfunction

    function automatic ctr_t ctr_dec(input ctr_t c);
        return (c == CTR_STRONG_NT) ? c : c - 2'd1;
    endfunction

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [29:0]          target;
        ctr_t                 ctr;
    } btb_entry_t;

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Lookup is combinational; update and flush take effect at the clock edge.
module pc_btb
    import pc_pkg::*;
#(
    parameter int BTB_ENTRIES = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] lookup_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        flush
);

    localparam int IDX_W = idx_w(BTB_ENTRIES);

    btb_entry_t tbl [BTB_ENTRIES];

    logic [IDX_W-1:0]     lidx, uidx;
    logic [TAG_MAX_W-1:0] ltag, utag;
    logic                 lhit, uhit;
    logic                 unused_bits;

    assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0], upd_target[1:0]};

    assign lidx = lookup_pc[IDX_W+1:2];
    assign ltag = TAG_MAX_W'(lookup_pc[31:IDX_W+2]);
    assign uidx = upd_pc[IDX_W+1:2];
    assign utag = TAG_MAX_W'(upd_pc[31:IDX_W+2]);

    assign lhit        = tbl[lidx].valid && (tbl[lidx].tag == ltag);
    assign uhit        = tbl[uidx].valid && (tbl[uidx].tag == utag);
    assign pred_taken  = lhit && tbl[lidx].ctr[1];
    assign pred_target = lhit ? {tbl[lidx].target, 2'b00} : 32'h0;

    // Flush takes priority so a same-cycle update can never re-allocate.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < BTB_ENTRIES; i++)
                tbl[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WEAK_NT};
        end else if (flush) begin
            for (int i = 0; i < BTB_ENTRIES; i++)
                tbl[i].valid <= 1'b0;
        end else if (upd_valid) begin
            if (uhit) begin
                if (upd_taken) begin
                    tbl[uidx].ctr    <= ctr_inc(tbl[uidx].ctr);
                    tbl[uidx].target <= upd_target[31:2];
                end else begin
                    tbl[uidx].ctr <= ctr_dec(tbl[uidx].ctr);
                end
            end else if (upd_taken) begin
                tbl[uidx] <= '{valid: 1'b1, tag: utag, target: upd_target[31:2],
                               ctr: CTR_WEAK_T};
            end
        end
    end

endmodule

// File: rtl/pc_predict.sv
// Fetch-PC unit: PC register, pending-redirect holding register and next-PC
// selection (redirect > pending > BTB prediction > sequential).
module pc_predict
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        flush_btb,
    output logic [31:0] imemaddr,
    output logic [31:0] pc_plus4,
    output logic        pred_taken,
    output logic [31:0] pred_target
);

    localparam logic [29:0] RESET_WORD = RESET_PC[31:2];

    // PC and pending target are kept as word addresses; bits [1:0] are always 0.
    logic [29:0] pc_q, pc_d, pend_q, pend_d;
    logic        pending_q, pending_d;
    logic        unused_bits;

    assign unused_bits = ^{redirect_pc[1:0], pred_target[1:0], RESET_PC[1:0]};

    pc_btb #(.BTB_ENTRIES(BTB_ENTRIES)) u_btb (
        .CLK         (CLK),
        .nRST        (nRST),
        .lookup_pc   (imemaddr),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .flush       (flush_btb)
    );

    always_comb begin
        pc_d      = pc_q;
        pend_d    = pend_q;
        pending_d = pending_q;
        if (stall) begin
            if (redirect) begin
                pend_d    = redirect_pc[31:2];
                pending_d = 1'b1;
            end
        end else if (redirect) begin
            pc_d      = redirect_pc[31:2];
            pending_d = 1'b0;
        end else if (pending_q) begin
            pc_d      = pend_q;
            pending_d = 1'b0;
        end else if (pred_taken) begin
            pc_d = pred_target[31:2];
        end else begin
            pc_d = pc_q + 30'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_q      <= RESET_WORD;
            pend_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            pend_q    <= pend_d;
            pending_q <= pending_d;
        end
    end

    assign imemaddr = {pc_q, 2'b00};
    assign pc_plus4 = imemaddr + 32'd4;

endmodule

// File: tb/tb_pc_predict.sv
// Directed bench for pc_predict: reset, stall, pending redirect, BTB prediction,
// counter saturation, aliasing, flush, PC wrap and async reset mid-stall.
module tb_pc_predict;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        stall, redirect, upd_valid, upd_taken, flush_btb;
    logic [31:0] redirect_pc, upd_pc, upd_target;
    logic [31:0] imemaddr, pc_plus4, pred_target;
    logic        pred_taken;

    int errs   = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    pc_predict #(.RESET_PC(32'h0), .BTB_ENTRIES(16)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .flush_btb   (flush_btb),
        .imemaddr    (imemaddr),
        .pc_plus4    (pc_plus4),
        .pred_taken  (pred_taken),
        .pred_target (pred_target)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = taken;
        upd_target = tgt;
    endtask

    task automatic upd_off;
        upd_valid = 1'b0;
    endtask

    // Unstalled redirect: lands on imemaddr after one edge.
    task automatic jump(input logic [31:0] pc);
        stall       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = pc;
        step();
        redirect = 1'b0;
    endtask

    initial begin
        nRST = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; flush_btb = 1'b0;

        // T1 reset
        repeat (2) step();
        chk("rst_pc", imemaddr, 32'h0);
        chk("rst_pred", {31'h0, pred_taken}, 32'h0);
        chk("rst_tgt", pred_target, 32'h0);
        nRST = 1'b1;
        chk("rel_pc0", imemaddr, 32'h0);
        chk("rel_plus4", pc_plus4, 32'h4);
        step(); chk("seq_4", imemaddr, 32'h4);
        step(); chk("seq_8", imemaddr, 32'h8);

        // T2 stall at 0x10
        step(); step();
        chk("at_10", imemaddr, 32'h10);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); chk("stall_hold", imemaddr, 32'h10);
        end
        stall = 1'b0;
        step(); chk("stall_drop", imemaddr, 32'h14);

        // T3 pending redirects
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
        step(); chk("pend_hold1", imemaddr, 32'h14);
        redirect_pc = 32'h300;
        step(); chk("pend_hold2", imemaddr, 32'h14);
        redirect = 1'b0;
        step(); chk("pend_hold3", imemaddr, 32'h14);
        stall = 1'b0;
        step(); chk("pend_apply", imemaddr, 32'h300);
        step(); chk("pend_clear", imemaddr, 32'h304);
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
        step();
        stall = 1'b0; redirect_pc = 32'h400;
        step(); chk("fresh_wins", imemaddr, 32'h400);
        redirect = 1'b0;
        step(); chk("fresh_clears", imemaddr, 32'h404);
        jump(32'h503);
        chk("redir_align", imemaddr, 32'h500);

        // T4 predict
        upd(32'h40, 1'b1, 32'h100);
        step(); upd_off();
        jump(32'h40);
        chk("pred_hit", {31'h0, pred_taken}, 32'h1);
        chk("pred_tgt", pred_target, 32'h100);
        step(); chk("pred_follow", imemaddr, 32'h100);
        chk("same_idx_other_tag", {31'h0, pred_taken}, 32'h0);
        step(); chk("after_tgt", imemaddr, 32'h104);

        // T5 counter walk with PC held at 0x40
        jump(32'h40);
        stall = 1'b1;
        upd(32'h40, 1'b0, 32'h0); step(); chk("ctr_01", {31'h0, pred_taken}, 32'h0);
        step(); chk("ctr_00", {31'h0, pred_taken}, 32'h0);
        step(); chk("ctr_00_hold", {31'h0, pred_taken}, 32'h0);
        upd(32'h40, 1'b1, 32'h100); step(); chk("ctr_up01", {31'h0, pred_taken}, 32'h0);
        step(); chk("ctr_up10", {31'h0, pred_taken}, 32'h1);
        step(); chk("ctr_up11", {31'h0, pred_taken}, 32'h1);
        upd(32'h40, 1'b1, 32'h183); step(); chk("ctr_sat11", {31'h0, pred_taken}, 32'h1);
        chk("tgt_update", pred_target, 32'h180);
        upd(32'h40, 1'b0, 32'h0); step(); chk("ctr_dn10", {31'h0, pred_taken}, 32'h1);
        step(); chk("ctr_dn01", {31'h0, pred_taken}, 32'h0);
        chk("imem_held", imemaddr, 32'h40);

        // T6 alias and flush
        upd(32'h40, 1'b1, 32'h100); step(); upd_off();
        chk("repredict", {31'h0, pred_taken}, 32'h1);
        jump(32'h80);
        chk("alias_miss", {31'h0, pred_taken}, 32'h0);
        stall = 1'b1;
        upd(32'h80, 1'b0, 32'h900); step(); upd_off();
        chk("nt_no_alloc", {31'h0, pred_taken}, 32'h0);
        flush_btb = 1'b1; upd(32'h80, 1'b1, 32'h900);
        step(); flush_btb = 1'b0; upd_off();
        chk("flush_no_alloc", {31'h0, pred_taken}, 32'h0);
        jump(32'h40);
        chk("flush_cleared", {31'h0, pred_taken}, 32'h0);
        step(); chk("flush_seq", imemaddr, 32'h44);

        // PC wrap
        jump(32'hFFFF_FFFC);
        chk("wrap_plus4", pc_plus4, 32'h0);
        step(); chk("wrap_pc", imemaddr, 32'h0);

        // Async reset mid-stall with a redirect pending and a live BTB entry
        upd(32'h40, 1'b1, 32'h100); step(); upd_off();
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h700;
        step(); redirect = 1'b0;
        #2 nRST = 1'b0;
        #1 chk("async_rst_pc", imemaddr, 32'h0);
        #3 nRST = 1'b1;
        stall = 1'b0;
        step(); chk("rst_drops_pend", imemaddr, 32'h4);
        jump(32'h40);
        chk("rst_clears_btb", {31'h0, pred_taken}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
